dfd_cla_debug_signals_seq_detect: RTL and testbench

//  Multi-channel successor of the CLA debug-signal transition matcher. Each of NUM_CH channels masks

---
 rtl/dfd_cla_debug_signals_seq_detect_pkg.sv | 30 +++
 rtl/dfd_cla_debug_signals_seq_detect_if.sv | 44 ++++
 rtl/dfd_cla_debug_signals_seq_detect_seq_ch.sv | 148 ++++++++++++++
 rtl/dfd_cla_debug_signals_seq_detect.sv | 65 ++++++
 tb/tb_dfd_cla_debug_signals_seq_detect.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dfd_cla_debug_signals_seq_detect_pkg.sv
// Shared types and defaults for the CLA debug-signal sequence detector.
//   seq_mode_e  : per-channel match mode (STRICT / WINDOW / CHANGE, 2'b11 acts as STRICT)
//   seq_state_e : STRICT/WINDOW transition-matcher states
//   DEF_*       : default widths used by the top, channel and interface
package dfd_cla_pkg;

    localparam int DEBUG_SIGNALS_WIDTH = 8;
    localparam int DEF_NUM_CH          = 4;
    localparam int DEF_GAP_W           = 8;
    localparam int DEF_CNT_W           = 16;

    typedef enum logic [1:0] {
        SEQ_STRICT = 2'b00,
        SEQ_WINDOW = 2'b01,
        SEQ_CHANGE = 2'b10
    } seq_mode_e;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ARMED,
        SEQ_WAIT
    } seq_state_e;

    // Only WINDOW honours the programmed gap; STRICT and the reserved
    // encoding both behave as a window of zero.
    function automatic logic seqUsesWindow(input logic [1:0] mode);
        return mode == SEQ_WINDOW;
    endfunction

endpackage

// File: rtl/dfd_cla_debug_signals_seq_detect_if.sv
// Configuration/observation bundle of the sequence detector.
//   debug_signals : observed debug bus
//   cfg_*         : per-channel enable, mode, mask, from/to values, max gap
//   cnt_clear     : per-channel hit counter clear pulse
//   match         : registered 1-cycle hit pulse per channel
//   any_match     : registered OR of all channel hits
//   hit_cnt       : per-channel saturating hit counter
//   hit_cnt_sat   : per-channel counter-is-saturated flag
// master = driver of configuration/bus (CSR + trace side), slave = detector.
interface dfd_cla_debug_signals_seq_detect_if
    import dfd_cla_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SIG_W  = DEBUG_SIGNALS_WIDTH,
    parameter int GAP_W  = DEF_GAP_W,
    parameter int CNT_W  = DEF_CNT_W
) ();

    logic [SIG_W-1:0]              debug_signals;
    logic [NUM_CH-1:0]             cfg_en;
    logic [NUM_CH-1:0][1:0]        cfg_mode;
    logic [NUM_CH-1:0][SIG_W-1:0]  cfg_mask;
    logic [NUM_CH-1:0][SIG_W-1:0]  cfg_from;
    logic [NUM_CH-1:0][SIG_W-1:0]  cfg_to;
    logic [NUM_CH-1:0][GAP_W-1:0]  cfg_window;
    logic [NUM_CH-1:0]             cnt_clear;
    logic [NUM_CH-1:0]             match;
    logic                          any_match;
    logic [NUM_CH-1:0][CNT_W-1:0]  hit_cnt;
    logic [NUM_CH-1:0]             hit_cnt_sat;

    modport master (
        output debug_signals, cfg_en, cfg_mode, cfg_mask, cfg_from, cfg_to,
               cfg_window, cnt_clear,
        input  match, any_match, hit_cnt, hit_cnt_sat
    );

    modport slave (
        input  debug_signals, cfg_en, cfg_mode, cfg_mask, cfg_from, cfg_to,
               cfg_window, cnt_clear,
        output match, any_match, hit_cnt, hit_cnt_sat
    );

endinterface

// File: rtl/dfd_cla_debug_signals_seq_detect_seq_ch.sv
// One detector channel: masks the debug bus, runs the from->to matcher
// (STRICT/WINDOW FSM or CHANGE compare) and keeps a saturating hit counter.
//   clock, reset_n   : block clock, async active-low reset
//   debug_signals_i  : observed debug bus
//   en_i, mode_i     : channel enable and mode
//   mask_i, from_i, to_i, window_i : match configuration
//   cnt_clear_i      : counter clear (wins over a same-cycle hit)
//   hit_o            : combinational hit for the current sample
//   match_o          : registered hit pulse
//   hit_cnt_o        : saturating hit count
//   hit_cnt_sat_o    : hit count is all-ones
module dfd_cla_debug_signals_seq_ch
    import dfd_cla_pkg::*;
#(
    parameter int SIG_W = DEBUG_SIGNALS_WIDTH,
    parameter int GAP_W = DEF_GAP_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [SIG_W-1:0] debug_signals_i,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic [SIG_W-1:0] mask_i,
    input  logic [SIG_W-1:0] from_i,
    input  logic [SIG_W-1:0] to_i,
    input  logic [GAP_W-1:0] window_i,
    input  logic             cnt_clear_i,
    output logic             hit_o,
    output logic             match_o,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic             hit_cnt_sat_o
);

    logic [SIG_W-1:0] masked;
    logic             fromMatch;
    logic             toMatch;
    logic             isChange;
    logic [GAP_W-1:0] effWindow;

    seq_state_e       state_q, state_d;
    logic [GAP_W-1:0] rem_q, rem_d;
    logic [SIG_W-1:0] prev_q, prev_d;
    logic             prevValid_q, prevValid_d;
    logic             match_q;
    logic [CNT_W-1:0] hitCnt_q, hitCnt_d;
    logic             hit;
    logic             cntSat;

    assign masked    = debug_signals_i & mask_i;
    assign fromMatch = (masked == from_i);
    assign toMatch   = (masked == to_i);
    assign isChange  = (mode_i == SEQ_CHANGE);
    assign effWindow = seqUsesWindow(mode_i) ? window_i : '0;
    assign cntSat    = &hitCnt_q;

    // Matcher next state. A disabled channel forgets everything except its
    // counter. In ARMED a to-match always hits, even when it is also a new
    // from-match (from==to re-arms and keeps hitting). rem holds the number
    // of WAIT samples still allowed before the window closes.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        prev_d      = prev_q;
        prevValid_d = prevValid_q;
        hit         = 1'b0;
        if (!en_i) begin
            state_d     = SEQ_IDLE;
            rem_d       = '0;
            prevValid_d = 1'b0;
        end else if (isChange) begin
            hit         = prevValid_q && (masked != prev_q);
            prev_d      = masked;
            prevValid_d = 1'b1;
        end else begin
            unique case (state_q)
                SEQ_IDLE: begin
                    if (fromMatch) state_d = SEQ_ARMED;
                end
                SEQ_ARMED: begin
                    hit = toMatch;
                    if (fromMatch) begin
                        state_d = SEQ_ARMED;
                    end else if (toMatch || effWindow == '0) begin
                        state_d = SEQ_IDLE;
                    end else begin
                        state_d = SEQ_WAIT;
                        rem_d   = effWindow;
                    end
                end
                SEQ_WAIT: begin
                    if (toMatch) begin
                        hit     = 1'b1;
                        state_d = fromMatch ? SEQ_ARMED : SEQ_IDLE;
                        rem_d   = '0;
                    end else if (fromMatch) begin
                        state_d = SEQ_ARMED;
                        rem_d   = '0;
                    end else if (rem_q == GAP_W'(1)) begin
                        state_d = SEQ_IDLE;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - GAP_W'(1);
                    end
                end
                default: begin
                    state_d = SEQ_IDLE;
                    rem_d   = '0;
                end
            endcase
        end
    end

    // Counter next value: clear beats a hit, and the count sticks at all-ones.
    always_comb begin
        hitCnt_d = hitCnt_q;
        if (cnt_clear_i) begin
            hitCnt_d = '0;
        end else if (hit && !cntSat) begin
            hitCnt_d = hitCnt_q + CNT_W'(1);
        end
    end

    // Channel state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SEQ_IDLE;
            rem_q       <= '0;
            prev_q      <= '0;
            prevValid_q <= 1'b0;
            match_q     <= 1'b0;
            hitCnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            prev_q      <= prev_d;
            prevValid_q <= prevValid_d;
            match_q     <= hit;
            hitCnt_q    <= hitCnt_d;
        end
    end

    assign hit_o         = hit;
    assign match_o       = match_q;
    assign hit_cnt_o     = hitCnt_q;
    assign hit_cnt_sat_o = cntSat;

endmodule

// File: rtl/dfd_cla_debug_signals_seq_detect.sv
// Multi-channel CLA debug-signal transition matcher. Each channel is an
// independent dfd_cla_debug_signals_seq_ch; the top adds the registered
// any_match OR so it lines up with the per-channel match pulses.
//   clock   : block clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of the detector interface (debug bus, per-channel
//             configuration, counter clears, match/any_match/hit_cnt/sat)
module dfd_cla_debug_signals_seq_detect
    import dfd_cla_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SIG_W  = DEBUG_SIGNALS_WIDTH,
    parameter int GAP_W  = DEF_GAP_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                               clock,
    input  logic                               reset_n,
    dfd_cla_debug_signals_seq_detect_if.slave  bus
);

    logic [NUM_CH-1:0]            chHit;
    logic [NUM_CH-1:0]            chMatch;
    logic [NUM_CH-1:0]            chSat;
    logic [NUM_CH-1:0][CNT_W-1:0] chCnt;
    logic                         anyMatch_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : gCh
        dfd_cla_debug_signals_seq_ch #(
            .SIG_W (SIG_W),
            .GAP_W (GAP_W),
            .CNT_W (CNT_W)
        ) uCh (
            .clock           (clock),
            .reset_n         (reset_n),
            .debug_signals_i (bus.debug_signals),
            .en_i            (bus.cfg_en[c]),
            .mode_i          (bus.cfg_mode[c]),
            .mask_i          (bus.cfg_mask[c]),
            .from_i          (bus.cfg_from[c]),
            .to_i            (bus.cfg_to[c]),
            .window_i        (bus.cfg_window[c]),
            .cnt_clear_i     (bus.cnt_clear[c]),
            .hit_o           (chHit[c]),
            .match_o         (chMatch[c]),
            .hit_cnt_o       (chCnt[c]),
            .hit_cnt_sat_o   (chSat[c])
        );
    end

    // any_match is built from the raw hits and registered here, so it rises
    // and falls in exactly the same cycle as the per-channel match flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            anyMatch_q <= 1'b0;
        end else begin
            anyMatch_q <= |chHit;
        end
    end

    assign bus.match       = chMatch;
    assign bus.any_match   = anyMatch_q;
    assign bus.hit_cnt     = chCnt;
    assign bus.hit_cnt_sat = chSat;

endmodule

// File: tb/tb_dfd_cla_debug_signals_seq_detect.sv
// Directed bench for the CLA debug-signal sequence detector (4 channels,
// 8-bit bus, 4-bit counters so saturation is reachable quickly).
module tb_dfd_cla_debug_signals_seq_detect;
    import dfd_cla_pkg::*;

    localparam int NUM_CH = 4;
    localparam int SIG_W  = 8;
    localparam int GAP_W  = 8;
    localparam int CNT_W  = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   nCompared   = 0;
    int   nMismatched = 0;

    dfd_cla_debug_signals_seq_detect_if #(
        .NUM_CH (NUM_CH), .SIG_W (SIG_W), .GAP_W (GAP_W), .CNT_W (CNT_W)
    ) dbg ();

    dfd_cla_debug_signals_seq_detect #(
        .NUM_CH (NUM_CH), .SIG_W (SIG_W), .GAP_W (GAP_W), .CNT_W (CNT_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (dbg)
    );

    always #5 clock = ~clock;

    // Drive one bus sample (and optional counter clears) for one clock,
    // returning #1 after the edge that registers its result.
    task automatic applyStimulus(input logic [7:0] val, input logic [3:0] clr);
        @(negedge clock);
        dbg.debug_signals = val;
        dbg.cnt_clear     = clr;
        @(posedge clock);
        #1;
        dbg.cnt_clear = '0;
    endtask

    // Disable channel, program it and clear its counter, then re-enable.
    task automatic configCh(input int c, input logic [1:0] mode, input logic [7:0] mask,
                            input logic [7:0] from, input logic [7:0] to,
                            input logic [7:0] win);
        @(negedge clock);
        dbg.cfg_en[c]     = 1'b0;
        dbg.cfg_mode[c]   = mode;
        dbg.cfg_mask[c]   = mask;
        dbg.cfg_from[c]   = from;
        dbg.cfg_to[c]     = to;
        dbg.cfg_window[c] = win;
        dbg.cnt_clear[c]  = 1'b1;
        dbg.debug_signals = 8'h00;
        @(posedge clock);
        #1;
        dbg.cnt_clear[c] = 1'b0;
        dbg.cfg_en[c]    = 1'b1;
    endtask

    task automatic disableAll();
        @(negedge clock);
        dbg.cfg_en = '0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        nCompared++;
        if (dbg.match !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL reset_match: got %b expected %b", dbg.match, 4'b0000);
        end
        nCompared++;
        if (dbg.any_match !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_any: got %b expected 0", dbg.any_match);
        end
        nCompared++;
        if (dbg.hit_cnt !== 16'h0000) begin
            nMismatched++;
            $display("[TB] FAIL reset_cnt: got %h expected 0000", dbg.hit_cnt);
        end
        nCompared++;
        if (dbg.hit_cnt_sat !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL reset_sat: got %b expected 0000", dbg.hit_cnt_sat);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_strict();
        logic [7:0] busV [7];
        logic       expV [7];
        busV = '{8'h01, 8'h02, 8'h00, 8'h01, 8'h03, 8'h02, 8'h00};
        expV = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
        disableAll();
        configCh(0, SEQ_STRICT, 8'hFF, 8'h01, 8'h02, 8'h00);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(busV[i], 4'h0);
            nCompared++;
            if (dbg.match !== {3'b000, expV[i]} || dbg.any_match !== expV[i]) begin
                nMismatched++;
                $display("[TB] FAIL strict step %0d: got match=%b any=%b expected match=%b",
                         i, dbg.match, dbg.any_match, {3'b000, expV[i]});
            end
        end
        nCompared++;
        if (dbg.hit_cnt[0] !== 4'd1) begin
            nMismatched++;
            $display("[TB] FAIL strict_cnt: got %0d expected 1", dbg.hit_cnt[0]);
        end
    endtask

    task automatic test_window();
        logic [7:0] busV [16];
        logic       expV [16];
        busV = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
                 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
                 8'h01, 8'h00, 8'h01, 8'h00, 8'h02};
        expV = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        disableAll();
        configCh(0, SEQ_WINDOW, 8'hFF, 8'h01, 8'h02, 8'd3);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(busV[i], 4'h0);
            nCompared++;
            if (dbg.match !== {3'b000, expV[i]}) begin
                nMismatched++;
                $display("[TB] FAIL window step %0d: got %b expected %b",
                         i, dbg.match, {3'b000, expV[i]});
            end
        end
        nCompared++;
        if (dbg.hit_cnt[0] !== 4'd2) begin
            nMismatched++;
            $display("[TB] FAIL window_cnt: got %0d expected 2", dbg.hit_cnt[0]);
        end
    endtask

    task automatic test_strict_equiv();
        logic [1:0] modeV [3];
        logic [7:0] winV  [3];
        logic [7:0] busV  [5];
        logic       expV  [5];
        logic [7:0] busE  [6];
        logic       expE  [6];
        modeV = '{SEQ_WINDOW, 2'b11, SEQ_STRICT};
        winV  = '{8'd0, 8'd3, 8'd3};
        busV  = '{8'h01, 8'h00, 8'h02, 8'h01, 8'h02};
        expV  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        busE  = '{8'h05, 8'h05, 8'h00, 8'h05, 8'h05, 8'h05};
        expE  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        disableAll();
        for (int m = 0; m < 3; m++) begin
            configCh(0, modeV[m], 8'hFF, 8'h01, 8'h02, winV[m]);
            for (int i = 0; i < 5; i++) begin
                applyStimulus(busV[i], 4'h0);
                nCompared++;
                if (dbg.match !== {3'b000, expV[i]}) begin
                    nMismatched++;
                    $display("[TB] FAIL equiv mode=%b step %0d: got %b expected %b",
                             modeV[m], i, dbg.match, {3'b000, expV[i]});
                end
            end
        end
        configCh(0, SEQ_STRICT, 8'hFF, 8'h05, 8'h05, 8'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(busE[i], 4'h0);
            nCompared++;
            if (dbg.match !== {3'b000, expE[i]}) begin
                nMismatched++;
                $display("[TB] FAIL from_eq_to step %0d: got %b expected %b",
                         i, dbg.match, {3'b000, expE[i]});
            end
        end
    endtask

    task automatic test_change();
        logic [7:0] busV [6];
        logic       expV [6];
        busV = '{8'h15, 8'h25, 8'h26, 8'h37, 8'h47, 8'h40};
        expV = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        disableAll();
        configCh(0, SEQ_CHANGE, 8'h0F, 8'h00, 8'h00, 8'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(busV[i], 4'h0);
            nCompared++;
            if (dbg.match !== {3'b000, expV[i]}) begin
                nMismatched++;
                $display("[TB] FAIL change step %0d: got %b expected %b",
                         i, dbg.match, {3'b000, expV[i]});
            end
        end
        configCh(0, SEQ_CHANGE, 8'h0F, 8'h00, 8'h00, 8'd0);
        applyStimulus(8'h41, 4'h0);
        nCompared++;
        if (dbg.match !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL change_first_after_reenable: got %b expected 0000", dbg.match);
        end
    endtask

    task automatic test_counter();
        disableAll();
        configCh(0, SEQ_STRICT, 8'hFF, 8'h01, 8'h02, 8'd0);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(8'h01, 4'h0);
            applyStimulus(8'h02, 4'h0);
            if (i == 13) begin
                nCompared++;
                if (dbg.hit_cnt[0] !== 4'd14 || dbg.hit_cnt_sat !== 4'b0000) begin
                    nMismatched++;
                    $display("[TB] FAIL cnt_14: got cnt=%0d sat=%b expected 14/0000",
                             dbg.hit_cnt[0], dbg.hit_cnt_sat);
                end
            end
        end
        nCompared++;
        if (dbg.hit_cnt[0] !== 4'd15 || dbg.hit_cnt_sat !== 4'b0001) begin
            nMismatched++;
            $display("[TB] FAIL cnt_15: got cnt=%0d sat=%b expected 15/0001",
                     dbg.hit_cnt[0], dbg.hit_cnt_sat);
        end
        applyStimulus(8'h01, 4'h0);
        applyStimulus(8'h02, 4'h0);
        nCompared++;
        if (dbg.match !== 4'b0001 || dbg.hit_cnt[0] !== 4'd15) begin
            nMismatched++;
            $display("[TB] FAIL cnt_saturate: got match=%b cnt=%0d expected 0001/15",
                     dbg.match, dbg.hit_cnt[0]);
        end
        applyStimulus(8'h01, 4'h0);
        applyStimulus(8'h02, 4'h1);
        nCompared++;
        if (dbg.match !== 4'b0001 || dbg.hit_cnt[0] !== 4'd0 || dbg.hit_cnt_sat !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL cnt_clear_wins: got match=%b cnt=%0d sat=%b expected 0001/0/0000",
                     dbg.match, dbg.hit_cnt[0], dbg.hit_cnt_sat);
        end
    endtask

    task automatic test_reset_midwait();
        disableAll();
        configCh(0, SEQ_WINDOW, 8'hFF, 8'h01, 8'h02, 8'd3);
        configCh(1, SEQ_STRICT, 8'hFF, 8'h00, 8'h03, 8'd0);
        applyStimulus(8'h01, 4'h0);
        applyStimulus(8'h00, 4'h0);
        applyStimulus(8'h03, 4'h0);
        nCompared++;
        if (dbg.match !== 4'b0010 || dbg.any_match !== 1'b1 || dbg.hit_cnt[1] !== 4'd1) begin
            nMismatched++;
            $display("[TB] FAIL pre_reset: got match=%b any=%b cnt1=%0d expected 0010/1/1",
                     dbg.match, dbg.any_match, dbg.hit_cnt[1]);
        end
        #1;
        reset_n = 1'b0;
        #1;
        nCompared++;
        if (dbg.match !== 4'b0000 || dbg.any_match !== 1'b0 || dbg.hit_cnt !== 16'h0000) begin
            nMismatched++;
            $display("[TB] FAIL async_reset: got match=%b any=%b cnt=%h expected 0000/0/0000",
                     dbg.match, dbg.any_match, dbg.hit_cnt);
        end
        dbg.debug_signals = 8'h02;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(8'h02, 4'h0);
        nCompared++;
        if (dbg.match !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL no_stale_after_reset: got %b expected 0000", dbg.match);
        end
    endtask

    task automatic test_disable();
        disableAll();
        configCh(0, SEQ_STRICT, 8'hFF, 8'h01, 8'h02, 8'd0);
        applyStimulus(8'h01, 4'h0);
        dbg.cfg_en[0] = 1'b0;
        applyStimulus(8'h02, 4'h0);
        nCompared++;
        if (dbg.match !== 4'b0000 || dbg.hit_cnt[0] !== 4'd0) begin
            nMismatched++;
            $display("[TB] FAIL disable_armed: got match=%b cnt=%0d expected 0000/0",
                     dbg.match, dbg.hit_cnt[0]);
        end
        dbg.cfg_en[0] = 1'b1;
        applyStimulus(8'h02, 4'h0);
        nCompared++;
        if (dbg.match !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL reenable_no_stale: got %b expected 0000", dbg.match);
        end
        applyStimulus(8'h01, 4'h0);
        applyStimulus(8'h02, 4'h0);
        dbg.cfg_en[0] = 1'b0;
        applyStimulus(8'h00, 4'h0);
        nCompared++;
        if (dbg.match !== 4'b0000 || dbg.hit_cnt[0] !== 4'd1) begin
            nMismatched++;
            $display("[TB] FAIL disable_drop: got match=%b cnt=%0d expected 0000/1",
                     dbg.match, dbg.hit_cnt[0]);
        end
    endtask

    task automatic test_multi_channel();
        logic [7:0] busV [6];
        logic [3:0] expV [6];
        busV = '{8'h01, 8'h02, 8'h03, 8'h81, 8'h12, 8'h00};
        expV = '{4'b0000, 4'b1001, 4'b0010, 4'b0100, 4'b1100, 4'b0000};
        disableAll();
        configCh(0, SEQ_STRICT, 8'hFF, 8'h01, 8'h02, 8'd0);
        configCh(1, SEQ_WINDOW, 8'hFF, 8'h01, 8'h03, 8'd2);
        configCh(2, SEQ_CHANGE, 8'h80, 8'h00, 8'h00, 8'd0);
        configCh(3, SEQ_STRICT, 8'h0F, 8'h01, 8'h02, 8'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(busV[i], 4'h0);
            nCompared++;
            if (dbg.match !== expV[i] || dbg.any_match !== (|expV[i])) begin
                nMismatched++;
                $display("[TB] FAIL multi step %0d: got match=%b any=%b expected %b/%b",
                         i, dbg.match, dbg.any_match, expV[i], |expV[i]);
            end
        end
        nCompared++;
        if (dbg.hit_cnt !== {4'd2, 4'd2, 4'd1, 4'd1}) begin
            nMismatched++;
            $display("[TB] FAIL multi_cnt: got %h expected 2211", dbg.hit_cnt);
        end
    endtask

    initial begin
        dbg.debug_signals = '0;
        dbg.cfg_en        = '0;
        dbg.cfg_mode      = '0;
        dbg.cfg_mask      = '0;
        dbg.cfg_from      = '0;
        dbg.cfg_to        = '0;
        dbg.cfg_window    = '0;
        dbg.cnt_clear     = '0;
        test_reset();
        test_strict();
        test_window();
        test_strict_equiv();
        test_change();
        test_counter();
        test_reset_midwait();
        test_disable();
        test_multi_channel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
